// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC register, request/ack fetch FSM, execute strobe and fetch timeout.
// Optional build macro IFETCH_JUMP_EN adds J-type (opcode 000010) next-PC handling.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [15:0] WAIT_LIMIT = 16'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        nPC_sel,
    output logic [31:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [31:0] PC_INIT   = {RESET_PC[31:2], 2'b00};
    localparam logic [15:0] LAST_WAIT = WAIT_LIMIT - 16'd1;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [31:0] pc_nxt, inst_nxt;
    logic        err_nxt;
    logic        commit;
    logic [31:0] pc4, br_off, target;

    // Handshake outputs are pure state decodes, so they drop the same cycle HALT/EXEC is entered.
    assign imem_req   = (state == REQ);
    assign inst_valid = (state == EXEC);
    assign imem_addr  = pc;
    assign commit     = inst_valid & ~stall;

    assign pc4    = pc + 32'd4;
    assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

    always_comb begin
        target = nPC_sel ? (pc4 + br_off) : pc4;
`ifdef IFETCH_JUMP_EN
        // Jump overrides the branch decision.
        if (inst[31:26] == 6'b000010)
            target = {pc4[31:28], inst[25:0], 2'b00};
`endif
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        inst_nxt     = inst;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = fetch_err;
        case (state)
            IDLE: begin
                state_nxt = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    inst_nxt     = imem_rdata;
                    wait_cnt_nxt = 16'd0;
                    state_nxt    = EXEC;
                end else if (wait_cnt == LAST_WAIT) begin
                    err_nxt   = 1'b1;
                    state_nxt = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                end
            end
            EXEC: begin
                if (commit) begin
                    pc_nxt    = target;
                    state_nxt = REQ;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= PC_INIT;
            inst      <= 32'd0;
            wait_cnt  <= 16'd0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            inst      <= inst_nxt;
            wait_cnt  <= wait_cnt_nxt;
            fetch_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: vector table of fetch transactions, scoreboard of fetched words, corner sequences.
module tb_ifetch_unit;

    logic        clk;
    logic        rst, imem_ack, stall, nPC_sel;
    logic [31:0] imem_rdata;
    logic        imem_req, inst_valid, fetch_err;
    logic [31:0] imem_addr, inst, pc;

    logic        rst_j, ack_j, stall_j, nsel_j;
    logic [31:0] rdata_j;
    logic        req_j, iv_j, err_j;
    logic [31:0] addr_j, inst_j, pc_j;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    ifetch_unit #(.RESET_PC(32'h0000_0103), .WAIT_LIMIT(16'd4)) u_dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
        .inst_valid(inst_valid), .stall(stall), .nPC_sel(nPC_sel),
        .pc(pc), .fetch_err(fetch_err)
    );

    ifetch_unit #(.RESET_PC(32'h1000_0000), .WAIT_LIMIT(16'd255)) u_dut_j (
        .clk(clk), .rst(rst_j), .imem_req(req_j), .imem_addr(addr_j),
        .imem_ack(ack_j), .imem_rdata(rdata_j), .inst(inst_j),
        .inst_valid(iv_j), .stall(stall_j), .nPC_sel(nsel_j),
        .pc(pc_j), .fetch_err(err_j)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        int          waits;
        logic [31:0] data;
        int          stalls;
        logic        npc;
        logic [31:0] next_pc;
    } vec_t;

`ifdef IFETCH_JUMP_EN
    localparam logic [31:0] J6      = 32'h0000_0040;
    localparam logic [31:0] J2_NEXT = 32'h1000_0040;
    localparam logic [31:0] J3_NEXT = 32'h1000_0040;
`else
    localparam logic [31:0] J6      = 32'h0000_0048;
    localparam logic [31:0] J2_NEXT = 32'h1000_0004;
    localparam logic [31:0] J3_NEXT = 32'h1000_0048;
`endif

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 8) begin
            tick();
            n++;
        end
        check(name, {31'd0, imem_req}, 32'd1);
    endtask

    task automatic sb_pop(input string name, input logic [31:0] act);
        logic [31:0] exp;
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb_q.pop_front();
            check(name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 0, 32'h2000_0001, 0, 1'b0, 32'h0000_0104};
        vecs[1] = '{32'h0000_0104, 3, 32'h1234_FFCE, 2, 1'b0, 32'h0000_0108};
        vecs[2] = '{32'h0000_0108, 0, 32'h1000_FFCD, 0, 1'b1, 32'h0000_0040};
        vecs[3] = '{32'h0000_0040, 1, 32'h1000_FFFE, 0, 1'b1, 32'h0000_003C};
        vecs[4] = '{32'h0000_003C, 0, 32'h0000_0000, 1, 1'b0, 32'h0000_0040};
        vecs[5] = '{32'h0000_0040, 0, 32'h1000_FFFE, 0, 1'b0, 32'h0000_0044};
        vecs[6] = '{32'h0000_0044, 2, 32'h0800_0010, 0, 1'b0, J6};
        vecs[7] = '{J6,            0, 32'h0000_7FFF, 0, 1'b1, J6 + 32'd4 + 32'h0001_FFFC};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0; nPC_sel = 1'b0;
        rst_j = 1'b1; ack_j = 1'b0; rdata_j = 32'd0; stall_j = 1'b0; nsel_j = 1'b0;
        tick();
        tick();

        check("rst_pc", pc, 32'h0000_0100);
        check("rst_inst", inst, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);

        rst = 1'b0;
        check("cyc0_idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("cyc1_req", {31'd0, imem_req}, 32'd1);
        check("cyc1_addr", imem_addr, 32'h0000_0100);

        foreach (vecs[i]) begin
            wait_req($sformatf("v%0d_req", i));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            for (int w = 0; w < vecs[i].waits; w++) begin
                imem_ack = 1'b0;
                tick();
                check($sformatf("v%0d_w%0d_req", i, w), {31'd0, imem_req}, 32'd1);
                check($sformatf("v%0d_w%0d_addr", i, w), imem_addr, vecs[i].addr);
                check($sformatf("v%0d_w%0d_valid", i, w), {31'd0, inst_valid}, 32'd0);
            end
            imem_ack = 1'b1;
            imem_rdata = vecs[i].data;
            sb_q.push_back(vecs[i].data);
            tick();
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            check($sformatf("v%0d_valid", i), {31'd0, inst_valid}, 32'd1);
            check($sformatf("v%0d_exec_req", i), {31'd0, imem_req}, 32'd0);
            sb_pop($sformatf("v%0d_inst", i), inst);
            for (int s = 0; s < vecs[i].stalls; s++) begin
                stall = 1'b1;
                nPC_sel = ~vecs[i].npc;
                tick();
                check($sformatf("v%0d_s%0d_valid", i, s), {31'd0, inst_valid}, 32'd1);
                check($sformatf("v%0d_s%0d_inst", i, s), inst, vecs[i].data);
                check($sformatf("v%0d_s%0d_pc", i, s), pc, vecs[i].addr);
            end
            stall = 1'b0;
            nPC_sel = vecs[i].npc;
            tick();
            nPC_sel = 1'b0;
            check($sformatf("v%0d_next_pc", i), pc, vecs[i].next_pc);
            check($sformatf("v%0d_next_addr", i), imem_addr, vecs[i].next_pc);
            check($sformatf("v%0d_after_valid", i), {31'd0, inst_valid}, 32'd0);
        end

        // Timeout: we sit in the first REQ cycle; four unanswered cycles must halt.
        for (int k = 0; k < 4; k++) begin
            check($sformatf("to_req%0d", k), {31'd0, imem_req}, 32'd1);
            check($sformatf("to_err%0d", k), {31'd0, fetch_err}, 32'd0);
            tick();
        end
        check("to_err_set", {31'd0, fetch_err}, 32'd1);
        check("to_req_low", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hFFFF_0000;
        stall = 1'b1;
        tick();
        tick();
        imem_ack = 1'b0;
        stall = 1'b0;
        check("halt_err_sticky", {31'd0, fetch_err}, 32'd1);
        check("halt_req", {31'd0, imem_req}, 32'd0);
        check("halt_valid", {31'd0, inst_valid}, 32'd0);
        check("halt_pc", pc, vecs[7].next_pc);
        check("halt_inst", inst, vecs[7].data);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rerst_err", {31'd0, fetch_err}, 32'd0);
        check("rerst_pc", pc, 32'h0000_0100);
        tick();
        check("rerst_req", {31'd0, imem_req}, 32'd1);
        check("rerst_addr", imem_addr, 32'h0000_0100);

        // Reset mid-wait, then an ack during IDLE must be discarded.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        check("mw_idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        imem_ack = 1'b0;
        check("mw_req", {31'd0, imem_req}, 32'd1);
        check("mw_inst0", inst, 32'd0);
        check("mw_valid0", {31'd0, inst_valid}, 32'd0);
        tick();
        check("mw_inst1", inst, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hAAAA_5555;
        sb_q.push_back(32'hAAAA_5555);
        tick();
        imem_ack = 1'b0;
        check("mw_valid", {31'd0, inst_valid}, 32'd1);
        sb_pop("mw_inst", inst);

        // Jump opcode at 0x1000_0000 on the second instance.
        rst_j = 1'b0;
        tick();
        check("j_req", {31'd0, req_j}, 32'd1);
        check("j_addr", addr_j, 32'h1000_0000);
        ack_j = 1'b1;
        rdata_j = 32'h0800_0010;
        tick();
        ack_j = 1'b0;
        check("j_valid", {31'd0, iv_j}, 32'd1);
        tick();
        check("j_next_pc", pc_j, J2_NEXT);
        check("j_next_addr", addr_j, J2_NEXT);
        ack_j = 1'b1;
        rdata_j = 32'h0800_0010;
        tick();
        ack_j = 1'b0;
        nsel_j = 1'b1;
        tick();
        nsel_j = 1'b0;
        check("j_prio_pc", pc_j, J3_NEXT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
